// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: serial double-dabble conversion, then
// overflow saturation and optional leading-zero blanking into decoder codes.
module bcd_display_ctrl #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blankLeading,
    output logic                  ready,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  done,
    output logic                  overflow
);

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FORMAT  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [SW-1:0]       bcd_r;
    logic [WIDTH-1:0]    shift_r;
    logic [CW-1:0]       cnt_r;
    logic                blank_r;
    logic                armed_r;
    logic                accept_s;
    logic [SW-1:0]       adj_s;
    logic [4*DIGITS-1:0] fmt_digits_s;
    logic                fmt_ovf_s;
    logic                lead_s;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift.
    function automatic logic [SW-1:0] add3_step(input logic [SW-1:0] bcd);
        logic [SW-1:0] res;
        res = bcd;
        for (int k = 0; k < DIGITS + 1; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end else begin
                res[4*k +: 4] = bcd[4*k +: 4];
            end
        end
        return res;
    endfunction

    // armed_r keeps the release edge of rst_n from also being an accept edge.
    assign accept_s = valid && (state_r == IDLE) && armed_r;
    assign ready    = (state_r == IDLE);
    assign adj_s    = add3_step(bcd_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = CONVERT;
                else          next_state_s = IDLE;
            end
            CONVERT: begin
                if (cnt_r == CW'(WIDTH - 1)) next_state_s = FORMAT;
                else                         next_state_s = CONVERT;
            end
            FORMAT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Saturate on a nonzero top scratch digit, otherwise blank leading zeros on request.
    always_comb begin
        fmt_digits_s = {(4*DIGITS){1'b0}};
        fmt_ovf_s    = (bcd_r[SW-1 -: 4] != 4'd0);
        lead_s       = blank_r;
        if (fmt_ovf_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                fmt_digits_s[4*i +: 4] = 4'h9;
            end
        end else begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead_s && (bcd_r[4*i +: 4] == 4'd0)) begin
                    fmt_digits_s[4*i +: 4] = 4'hF;
                end else begin
                    lead_s                 = 1'b0;
                    fmt_digits_s[4*i +: 4] = bcd_r[4*i +: 4];
                end
            end
            fmt_digits_s[3:0] = bcd_r[3:0];
        end
    end

    // Conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r    <= {SW{1'b0}};
            shift_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            blank_r  <= 1'b0;
            armed_r  <= 1'b0;
            digits   <= {(4*DIGITS){1'b1}};
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r <= value;
                        blank_r <= blankLeading;
                        bcd_r   <= {SW{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        shift_r <= shift_r;
                    end
                end
                CONVERT: begin
                    bcd_r   <= {adj_s[SW-2:0], shift_r[WIDTH-1]};
                    shift_r <= {shift_r[WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + CW'(1);
                end
                FORMAT: begin
                    digits   <= fmt_digits_s;
                    overflow <= fmt_ovf_s;
                    done     <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: hand-computed digit codes, latency,
// overflow, ignored requests while busy, and mid-conversion reset.
module tb_bcd_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [19:0] value;
    logic        blank_leading;
    logic        ready;
    logic [23:0] digits;
    logic        done;
    logic        overflow;

    int total_cnt = 0;
    int bad_cnt   = 0;

    bcd_display_ctrl #(.WIDTH(20), .DIGITS(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .value        (value),
        .blankLeading (blank_leading),
        .ready        (ready),
        .digits       (digits),
        .done         (done),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one request for one edge; caller positions time away from posedge.
    task automatic start(input logic [19:0] v, input logic b);
        valid         = 1'b1;
        value         = v;
        blank_leading = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // Wait for done (bounded), then check latency, digits, overflow and ready.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [23:0] exp_dig, input logic exp_ovf);
        int n;
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_dig"}, {8'd0, digits}, {8'd0, exp_dig});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic count_done(input string tag, input int cycles, input int exp_pulses);
        int p;
        p = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) p++;
        end
        chk(tag, p, exp_pulses);
    endtask

    initial begin
        rst_n         = 1'b0;
        valid         = 1'b0;
        value         = 20'd0;
        blank_leading = 1'b0;
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_dig", {8'd0, digits}, 32'h00FFFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back: each new request issues in the cycle done is high.
        start(20'd123456, 1'b1);
        wait_done("v123456", 21, 24'h123456, 1'b0);
        start(20'd42, 1'b1);
        wait_done("v42_blank", 21, 24'hFFFF42, 1'b0);
        start(20'd42, 1'b0);
        wait_done("v42_noblank", 21, 24'h000042, 1'b0);
        start(20'd0, 1'b1);
        wait_done("v0_blank", 21, 24'hFFFFF0, 1'b0);
        start(20'd1000000, 1'b1);
        wait_done("v1000000", 21, 24'h999999, 1'b1);
        start(20'd1048575, 1'b0);
        wait_done("v1048575", 21, 24'h999999, 1'b1);
        start(20'd7, 1'b1);
        wait_done("v7", 21, 24'hFFFFF7, 1'b0);
        start(20'd999999, 1'b0);
        wait_done("v999999", 21, 24'h999999, 1'b0);
        start(20'd100500, 1'b1);
        wait_done("v100500", 21, 24'h100500, 1'b0);

        // Request while busy is dropped.
        start(20'd555, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        valid = 1'b1;
        value = 20'd7;
        chk("busy_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_done("v555", 16, 24'hFFF555, 1'b0);
        count_done("v555_once", 30, 0);
        chk("v555_hold", {8'd0, digits}, 32'h00FFF555);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start(20'd123, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_dig", {8'd0, digits}, 32'h00FFFFFF);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_done("mid_rst_nodone", 25, 0);
        @(negedge clk);
        start(20'd99, 1'b0);
        wait_done("after_rst", 21, 24'h000099, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
